// File: rtl/loader_pkg.sv
// Shared types and constants for the UART memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    AHI,
    ALO,
    LHI,
    LLO,
    DATA,
    SUM
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int DEFAULT_ADDR_BITS = 14;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, glitch rejection.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_reg, state_next;
  logic [1:0]       sync_reg;
  logic             prev_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;
  logic             rx_s;

  assign rx_s       = sync_reg[1];
  assign data       = data_reg;
  assign byte_valid = valid_reg;
  assign frame_err  = ferr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RX_IDLE;
      sync_reg  <= 2'b11;
      prev_reg  <= 1'b1;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= {sync_reg[0], rx};
      prev_reg  <= rx_s;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        // Edge-qualified so a line held low after a framing error does not retrigger.
        if (prev_reg && !rx_s) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_reg == FULL_M1) begin
          state_next = RX_IDLE;
          if (rx_s) begin
            valid_next = 1'b1;
            data_next  = shift_reg;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Framed serial boot loader: parses sync/address/length/payload/checksum and drives a memory write port.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_BITS    = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS    = 8,
  parameter int TIMEOUT_CLKS = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [ADDR_BITS-1:0] addr_wr,
  output logic [DATA_BITS-1:0] data_wr,
  output logic                 wren,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
  logic [7:0]           hi_reg, hi_next;
  logic [15:0]          len_reg, len_next;
  logic [7:0]           sum_reg, sum_next;
  logic [TW-1:0]        tmo_reg, tmo_next;
  logic [ADDR_BITS-1:0] addr_wr_reg, addr_wr_next;
  logic [DATA_BITS-1:0] data_wr_reg, data_wr_next;
  logic                 wren_reg, wren_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic [TW-1:0]        tmo_inc;

  assign addr_wr = addr_wr_reg;
  assign data_wr = data_wr_reg;
  assign wren    = wren_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign tmo_inc = tmo_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= SYNC;
      ptr_reg     <= '0;
      hi_reg      <= '0;
      len_reg     <= '0;
      sum_reg     <= '0;
      tmo_reg     <= '0;
      addr_wr_reg <= '0;
      data_wr_reg <= '0;
      wren_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      hi_reg      <= hi_next;
      len_reg     <= len_next;
      sum_reg     <= sum_next;
      tmo_reg     <= tmo_next;
      addr_wr_reg <= addr_wr_next;
      data_wr_reg <= data_wr_next;
      wren_reg    <= wren_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    hi_next      = hi_reg;
    len_next     = len_reg;
    sum_next     = sum_reg;
    tmo_next     = tmo_reg;
    addr_wr_next = addr_wr_reg;
    data_wr_next = data_wr_reg;
    wren_next    = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    if (rx_ferr) begin
      err_next   = 1'b1;
      busy_next  = 1'b0;
      tmo_next   = '0;
      state_next = SYNC;
    end else if (rx_valid) begin
      tmo_next = '0;
      // Checksum covers everything after the sync byte, including SUM itself.
      sum_next = sum_reg + rx_data;
      case (state_reg)
        SYNC: begin
          sum_next = '0;
          if (rx_data == SYNC_BYTE) begin
            busy_next  = 1'b1;
            state_next = AHI;
          end
        end
        AHI: begin
          hi_next    = rx_data;
          state_next = ALO;
        end
        ALO: begin
          ptr_next   = ADDR_BITS'({hi_reg, rx_data});
          state_next = LHI;
        end
        LHI: begin
          len_next   = {rx_data, 8'h00};
          state_next = LLO;
        end
        LLO: begin
          len_next   = {len_reg[15:8], rx_data};
          state_next = ({len_reg[15:8], rx_data} == 16'd0) ? SUM : DATA;
        end
        DATA: begin
          wren_next    = 1'b1;
          addr_wr_next = ptr_reg;
          data_wr_next = DATA_BITS'(rx_data);
          ptr_next     = ptr_reg + 1'b1;
          len_next     = len_reg - 1'b1;
          if (len_reg == 16'd1) state_next = SUM;
        end
        SUM: begin
          done_next  = (sum_next == 8'h00);
          err_next   = (sum_next != 8'h00);
          busy_next  = 1'b0;
          state_next = SYNC;
        end
        default: state_next = SYNC;
      endcase
    end else if (state_reg != SYNC) begin
      tmo_next = tmo_inc;
      if (tmo_inc == TW'(TIMEOUT_CLKS)) begin
        err_next   = 1'b1;
        busy_next  = 1'b0;
        tmo_next   = '0;
        state_next = SYNC;
      end
    end else begin
      tmo_next = '0;
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: frame table plus timeout and mid-frame reset sequences.
module tb_uart_mem_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [13:0] addr_wr;
  logic [7:0]  data_wr;
  logic        wren, busy, done, err;

  uart_mem_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_BITS   (14),
    .DATA_BITS   (8),
    .TIMEOUT_CLKS(2000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .addr_wr(addr_wr),
    .data_wr(data_wr),
    .wren   (wren),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       n;
    logic [9:0][7:0]  b;
    logic [3:0]       bad;
    logic [1:0]       nw;
    logic [2:0][13:0] wa;
    logic [2:0][7:0]  wd;
    logic             ed;
    logic             ee;
  } vec_t;

  // Monitor: monotonic event counters and a write log, sampled on the falling edge.
  int          wr_total = 0;
  int          done_total = 0;
  int          err_total = 0;
  int          wren_long = 0;
  logic        wren_prev = 1'b0;
  logic [13:0] log_a[64];
  logic [7:0]  log_d[64];

  always @(negedge clk) begin
    if (wren) begin
      log_a[wr_total & 63] = addr_wr;
      log_d[wr_total & 63] = data_wr;
      wr_total = wr_total + 1;
    end
    if (wren && wren_prev) wren_long = wren_long + 1;
    if (done) done_total = done_total + 1;
    if (err) err_total = err_total + 1;
    wren_prev = wren;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int n, input logic [79:0] bytes, input int bad,
                              input int nw, input logic [41:0] wa, input logic [23:0] wd,
                              input logic ed, input logic ee);
    vec_t v;
    v.n   = 4'(n);
    v.bad = 4'(bad);
    v.nw  = 2'(nw);
    v.ed  = ed;
    v.ee  = ee;
    for (int i = 0; i < 10; i++) v.b[i] = bytes[79-8*i -: 8];
    for (int i = 0; i < 3; i++) begin
      v.wa[i] = wa[41-14*i -: 14];
      v.wd[i] = wd[23-8*i -: 8];
    end
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int wb, db, eb;
    wb = wr_total;
    db = done_total;
    eb = err_total;
    for (int i = 0; i < int'(v.n); i++) begin
      if (i == int'(v.n) - 1 && v.bad == 4'd15)
        check($sformatf("v%0d_busy_pre_sum", k), int'(busy), 1);
      send_byte(v.b[i], (i != int'(v.bad)));
    end
    repeat (20) @(negedge clk);
    check($sformatf("v%0d_nwrites", k), wr_total - wb, int'(v.nw));
    for (int j = 0; j < int'(v.nw); j++) begin
      check($sformatf("v%0d_addr%0d", k, j), int'(log_a[(wb + j) & 63]), int'(v.wa[j]));
      check($sformatf("v%0d_data%0d", k, j), int'(log_d[(wb + j) & 63]), int'(v.wd[j]));
    end
    check($sformatf("v%0d_done", k), done_total - db, int'(v.ed));
    check($sformatf("v%0d_err", k), err_total - eb, int'(v.ee));
    check($sformatf("v%0d_busy_after", k), int'(busy), 0);
    $display("vec %0d: writes=%0d done=%0d err=%0d", k, wr_total - wb, done_total - db,
             err_total - eb);
  endtask

  vec_t vecs[6];

  initial begin
    int eb, wb;
    // Checksums: 10+03+11+22+33=79 -> 87; 3F+FF+02+AA+BB=A5 -> 5B; 01+01+5A=5C -> A4.
    vecs[0] = mk(9, 80'hA5001000031122338700, 15, 3, {14'h0010, 14'h0011, 14'h0012},
                 {8'h11, 8'h22, 8'h33}, 1'b1, 1'b0);
    vecs[1] = mk(9, 80'hA5001000031122338800, 15, 3, {14'h0010, 14'h0011, 14'h0012},
                 {8'h11, 8'h22, 8'h33}, 1'b0, 1'b1);
    vecs[2] = mk(8, 80'hA53FFF0002AABB5B0000, 15, 2, {14'h3FFF, 14'h0000, 14'h0000},
                 {8'hAA, 8'hBB, 8'h00}, 1'b1, 1'b0);
    vecs[3] = mk(8, 80'h00FFA500000000000000, 15, 0, 42'd0, 24'd0, 1'b1, 1'b0);
    vecs[4] = mk(4, 80'hA5123400000000000000, 3, 0, 42'd0, 24'd0, 1'b0, 1'b1);
    vecs[5] = mk(7, 80'hA5010000015AA4000000, 15, 1, {14'h0100, 14'h0000, 14'h0000},
                 {8'h5A, 8'h00, 8'h00}, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_addr_wr", int'(addr_wr), 0);
    check("rst_data_wr", int'(data_wr), 0);
    check("rst_wren", int'(wren), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Inter-byte timeout after ALO.
    eb = err_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (1900) @(negedge clk);
    check("tmo_no_early_err", err_total - eb, 0);
    check("tmo_busy_waiting", int'(busy), 1);
    repeat (200) @(negedge clk);
    check("tmo_err_pulse", err_total - eb, 1);
    check("tmo_busy_low", int'(busy), 0);
    $display("timeout: err=%0d busy=%0d", err_total - eb, busy);
    run_vec(10, vecs[0]);

    // Reset while in DATA after one payload byte.
    eb = err_total;
    wb = wr_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (10) @(negedge clk);
    check("mid_one_write", wr_total - wb, 1);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_addr_wr", int'(addr_wr), 0);
    check("mid_rst_data_wr", int'(data_wr), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_wren", int'(wren), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_rst_no_err", err_total - eb, 0);
    $display("mid-frame reset: err=%0d", err_total - eb);
    run_vec(11, vecs[5]);

    check("wren_single_cycle", wren_long, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
